arbitro_de_acesso: RTL and testbench

Sequential arbiter that decides, cycle by cycle, which of the two requesters (user slot 0: CH0–CH3/BTN0–BTN1, user slot 1: CH4–CH7/BTN2–BTN3) drives the shared LED matrix and LED outputs. It sits between the switch/button inputs and the functionality decoders/multiplexers of `projeto`. It replaces the combinational priority selection with a registered grant:
- a minimum hold time per grant;
- preemption by higher-priority users;
- round-robin tie breaking;
- a reported losing user for the 7-segment display.

---
 rtl/arbitro_de_acesso_if.sv | 22 ++
 rtl/arbitro_de_acesso.sv | 186 ++++++++++++++++++
 tb/tb_arbitro_de_acesso.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_de_acesso_if.sv
// Request/grant bundle between the two user slots and the LED arbiter.
// The slave side is the arbiter. The master side is whatever drives the switches and buttons.
interface arbitro_de_acesso_if;
   logic [2:0] user0;
   logic [2:0] func0;
   logic [2:0] user1;
   logic [2:0] func1;
   logic [1:0] grant;
   logic [2:0] perdedor;
   logic       conflito;
   logic       hold_active;

   modport slave (
      input  user0, func0, user1, func1,
      output grant, perdedor, conflito, hold_active
   );

   modport master (
      output user0, func0, user1, func1,
      input  grant, perdedor, conflito, hold_active
   );
endinterface

// File: rtl/arbitro_de_acesso.sv
// Registered arbiter for the shared LED matrix/LED outputs.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no valid request, nobody drives the outputs
// ST_G0    | requester 0 owns the outputs (hold counter protects it)
// ST_G1    | requester 1 owns the outputs (hold counter protects it)
// ST_AMBOS | both request different functions, both drive
module arbitro_de_acesso #(
   parameter int HOLD_CYCLES = 1000
) (
   input logic                clock_i,
   input logic                reset_n_i,
   arbitro_de_acesso_if.slave arb_io
);

   localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_G0, ST_G1, ST_AMBOS} state_t;

   logic [11:0]   sync1_q, sync2_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rr_q, rr_d;
   logic [2:0]    hf_q, hf_d;
   logic [1:0]    grant_q, grant_d;
   logic [2:0]    perd_q, perd_d;
   logic          conf_q, conf_d;
   logic          hold_q, hold_d;

   logic [2:0] s_user0, s_func0, s_user1, s_func1;
   logic       req0, req1;
   state_t     arb_state;
   logic       arb_tie;
   logic       use_arb, reload;

   assign s_user0 = sync2_q[11:9];
   assign s_func0 = sync2_q[8:6];
   assign s_user1 = sync2_q[5:3];
   assign s_func1 = sync2_q[2:0];
   assign req0    = (s_func0 != 3'b000) && (s_user0 != 3'b000);
   assign req1    = (s_func1 != 3'b000) && (s_user1 != 3'b000);

   // Two-flop synchronizer for the raw switch/button inputs.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {arb_io.user0, arb_io.func0, arb_io.user1, arb_io.func1};
         sync2_q <= sync1_q;
      end
   end

   // Fresh arbitration decision: larger user code wins, ties go to the rr pointer.
   always_comb begin
      arb_state = ST_IDLE;
      arb_tie   = 1'b0;
      if (req0 && req1) begin
         if (s_func0 != s_func1) begin
            arb_state = ST_AMBOS;
         end else if (s_user0 > s_user1) begin
            arb_state = ST_G0;
         end else if (s_user1 > s_user0) begin
            arb_state = ST_G1;
         end else begin
            arb_tie   = 1'b1;
            arb_state = rr_q ? ST_G1 : ST_G0;
         end
      end else if (req0) begin
         arb_state = ST_G0;
      end else if (req1) begin
         arb_state = ST_G1;
      end
   end

   // Next-state, hold counter and output decode from the next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      hf_d    = hf_q;
      use_arb = 1'b0;
      reload  = 1'b0;
      case (state_q)
         ST_IDLE: use_arb = 1'b1;
         ST_G0: begin
            if (!req0 || (s_func0 != hf_q)) begin
               use_arb = 1'b1;
            end else if (req1 && (s_func1 != s_func0)) begin
               state_d = ST_AMBOS;
            end else if (req1 && (cnt_q == '0) && (s_user1 > s_user0)) begin
               state_d = ST_G1;
               reload  = 1'b1;
            end else begin
               cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
            end
         end
         ST_G1: begin
            if (!req1 || (s_func1 != hf_q)) begin
               use_arb = 1'b1;
            end else if (req0 && (s_func0 != s_func1)) begin
               state_d = ST_AMBOS;
            end else if (req0 && (cnt_q == '0) && (s_user0 > s_user1)) begin
               state_d = ST_G0;
               reload  = 1'b1;
            end else begin
               cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
            end
         end
         ST_AMBOS: begin
            if (!req0 || !req1 || (s_func0 == s_func1)) begin
               use_arb = 1'b1;
            end
         end
         default: use_arb = 1'b1;
      endcase

      // A grant picked by arb() is always a new grant, even for the same holder.
      if (use_arb) begin
         state_d = arb_state;
         if ((arb_state == ST_G0) || (arb_state == ST_G1)) begin
            reload = 1'b1;
         end
         if (arb_tie) begin
            rr_d = ~rr_q;
         end
      end
      if (reload) begin
         cnt_d = HOLD_LD;
         hf_d  = (state_d == ST_G1) ? s_func1 : s_func0;
      end
      if ((state_d == ST_IDLE) || (state_d == ST_AMBOS)) begin
         cnt_d = '0;
      end

      grant_d = 2'b00;
      conf_d  = 1'b0;
      perd_d  = 3'b000;
      case (state_d)
         ST_G0: begin
            grant_d = 2'b01;
            conf_d  = req1 && (s_func1 == s_func0);
            perd_d  = conf_d ? s_user1 : 3'b000;
         end
         ST_G1: begin
            grant_d = 2'b10;
            conf_d  = req0 && (s_func0 == s_func1);
            perd_d  = conf_d ? s_user0 : 3'b000;
         end
         ST_AMBOS: grant_d = 2'b11;
         default:  grant_d = 2'b00;
      endcase
      hold_d = (cnt_d != '0);
   end

   // State, counter, rr pointer and registered outputs.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rr_q    <= 1'b0;
         hf_q    <= 3'b000;
         grant_q <= 2'b00;
         perd_q  <= 3'b000;
         conf_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         hf_q    <= hf_d;
         grant_q <= grant_d;
         perd_q  <= perd_d;
         conf_q  <= conf_d;
         hold_q  <= hold_d;
      end
   end

   assign arb_io.grant       = grant_q;
   assign arb_io.perdedor    = perd_q;
   assign arb_io.conflito    = conf_q;
   assign arb_io.hold_active = hold_q;

endmodule

// File: tb/tb_arbitro_de_acesso.sv
// Bench for arbitro_de_acesso: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_arbitro_de_acesso;

   localparam int HOLD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   arbitro_de_acesso_if bus ();

   arbitro_de_acesso #(.HOLD_CYCLES(HOLD)) dut (
      .clock_i  (clk),
      .reset_n_i(rst_n),
      .arb_io   (bus)
   );

   always #5 clk = ~clk;

   // Model: owner 0 = nobody, 1 = requester 0, 2 = requester 1, 3 = both (equals Grant).
   int          m_own;
   int          m_cnt;
   bit          m_rr;
   logic [2:0]  m_hf;
   logic [1:0]  m_grant;
   logic [2:0]  m_perd;
   logic        m_conf;
   logic        m_hold;
   logic [11:0] m_pipe[$];

   task automatic model_reset();
      m_own = 0; m_cnt = 0; m_rr = 0; m_hf = 0;
      m_grant = 0; m_perd = 0; m_conf = 0; m_hold = 0;
      m_pipe = '{12'h000, 12'h000};
   endtask

   task automatic model_arb(input bit r0, input bit r1, input logic [2:0] u0, input logic [2:0] f0,
                            input logic [2:0] u1, input logic [2:0] f1, output int nxt);
      if (r0 && r1) begin
         if (f0 != f1)     nxt = 3;
         else if (u0 > u1) nxt = 1;
         else if (u1 > u0) nxt = 2;
         else begin
            nxt  = m_rr ? 2 : 1;
            m_rr = !m_rr;
         end
      end else if (r0) nxt = 1;
      else if (r1)     nxt = 2;
      else             nxt = 0;
   endtask

   task automatic model_step(input logic [11:0] raw);
      logic [11:0] x;
      logic [2:0]  u0, f0, u1, f1, uh, fh, uo, fo;
      bit          r0, r1, rh, ro, newg;
      int          nxt;
      m_pipe.push_back(raw);
      x = m_pipe.pop_front();
      {u0, f0, u1, f1} = x;
      r0 = (f0 != 0) && (u0 != 0);
      r1 = (f1 != 0) && (u1 != 0);
      nxt = m_own;
      newg = 0;
      if (m_own == 0) begin
         model_arb(r0, r1, u0, f0, u1, f1, nxt);
         newg = (nxt == 1 || nxt == 2);
      end else if (m_own == 3) begin
         if (!r0 || !r1 || f0 == f1) begin
            model_arb(r0, r1, u0, f0, u1, f1, nxt);
            newg = (nxt == 1 || nxt == 2);
         end
      end else begin
         rh = (m_own == 1) ? r0 : r1;  ro = (m_own == 1) ? r1 : r0;
         uh = (m_own == 1) ? u0 : u1;  uo = (m_own == 1) ? u1 : u0;
         fh = (m_own == 1) ? f0 : f1;  fo = (m_own == 1) ? f1 : f0;
         if (!rh || fh != m_hf) begin
            model_arb(r0, r1, u0, f0, u1, f1, nxt);
            newg = (nxt == 1 || nxt == 2);
         end else if (ro && fo != fh) begin
            nxt = 3;
         end else if (ro && m_cnt == 0 && uo > uh) begin
            nxt  = 3 - m_own;
            newg = 1;
         end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
         end
      end
      if (newg) begin
         m_cnt = HOLD;
         m_hf  = (nxt == 1) ? f0 : f1;
      end
      if (nxt == 0 || nxt == 3) m_cnt = 0;
      m_own   = nxt;
      m_grant = 2'(nxt);
      m_conf  = (nxt == 1 && r1 && f1 == f0) || (nxt == 2 && r0 && f0 == f1);
      m_perd  = !m_conf ? 3'b000 : (nxt == 1) ? u1 : u0;
      m_hold  = (m_cnt != 0);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model();
      chk("grant",    8'(bus.grant),       8'(m_grant));
      chk("perdedor", 8'(bus.perdedor),    8'(m_perd));
      chk("conflito", 8'(bus.conflito),    8'(m_conf));
      chk("hold",     8'(bus.hold_active), 8'(m_hold));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step({bus.user0, bus.func0, bus.user1, bus.func1});
      #1;
      chk_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drive(input logic [2:0] u0, input logic [2:0] f0, input logic [2:0] u1, input logic [2:0] f1);
      bus.user0 = u0; bus.func0 = f0; bus.user1 = u1; bus.func1 = f1;
   endtask

   task automatic chk_outs(input string tag, input logic [1:0] g, input logic [2:0] p, input logic c);
      chk({tag, "_grant"},    8'(bus.grant),    8'(g));
      chk({tag, "_perdedor"}, 8'(bus.perdedor), 8'(p));
      chk({tag, "_conflito"}, 8'(bus.conflito), 8'(c));
   endtask

   logic [2:0] users[4];

   initial begin
      users = '{3'b000, 3'b001, 3'b011, 3'b101};
      drive(0, 0, 0, 0);
      model_reset();
      #12;
      chk_outs("por", 2'b00, 3'b000, 1'b0);
      chk("por_hold", 8'(bus.hold_active), 8'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ticks(2);

      // Single request, 3-edge latency
      drive(3'b101, 3'b001, 3'b000, 3'b000);
      ticks(2);
      chk("single_latency", 8'(bus.grant), 8'h0);
      tick();
      chk_outs("single", 2'b01, 3'b000, 1'b0);
      chk("single_hold", 8'(bus.hold_active), 8'h1);
      drive(0, 0, 0, 0);
      ticks(4);

      // Same-function conflict, higher user wins
      drive(3'b101, 3'b001, 3'b001, 3'b001);
      ticks(3);
      chk_outs("conflict", 2'b01, 3'b001, 1'b1);
      drive(0, 0, 0, 0);
      ticks(4);

      // Different functions, both drive
      drive(3'b101, 3'b010, 3'b001, 3'b001);
      ticks(3);
      chk_outs("ambos", 2'b11, 3'b000, 1'b0);
      chk("ambos_hold", 8'(bus.hold_active), 8'h0);
      drive(0, 0, 0, 0);
      ticks(4);

      // Round-robin tie
      drive(3'b011, 3'b001, 3'b011, 3'b001);
      ticks(3);
      chk_outs("rr_first", 2'b01, 3'b011, 1'b1);
      drive(3'b011, 3'b000, 3'b011, 3'b000);
      ticks(3);
      chk("rr_drop", 8'(bus.grant), 8'h0);
      drive(3'b011, 3'b001, 3'b011, 3'b001);
      ticks(3);
      chk_outs("rr_second", 2'b10, 3'b011, 1'b1);

      // Asynchronous reset while Grant = 10, inputs kept applied
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_outs("async_rst", 2'b00, 3'b000, 1'b0);
      chk("async_rst_hold", 8'(bus.hold_active), 8'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ticks(2);
      chk("rst_release_latency", 8'(bus.grant), 8'h0);
      tick();
      chk("rst_release_grant", 8'(bus.grant), 8'h1);
      drive(0, 0, 0, 0);
      ticks(4);

      // Preemption after the hold expires
      drive(3'b001, 3'b001, 3'b000, 3'b000);
      tick();
      drive(3'b001, 3'b001, 3'b101, 3'b001);
      ticks(2);
      chk_outs("pre_grant", 2'b01, 3'b000, 1'b0);
      for (int i = 0; i < HOLD; i++) begin
         tick();
         chk_outs("pre_hold", 2'b01, 3'b101, 1'b1);
      end
      tick();
      chk_outs("pre_switch", 2'b10, 3'b001, 1'b1);
      drive(0, 0, 0, 0);
      ticks(4);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(3) == 0) begin
            if ($urandom_range(1) == 0) begin
               bus.user0 = users[$urandom_range(3)];
               bus.func0 = 3'($urandom_range(2));
            end else begin
               bus.user1 = users[$urandom_range(3)];
               bus.func1 = 3'($urandom_range(2));
            end
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
